// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings for the multicycle RV32I control path
// Holds the control FSM state set, opcode constants and the mux/ALU select
// encodings. The ALU decoder and datapath import the same encodings.
// The Moore output table for every state is kept in one place here.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BEQ,
        S_JAL,
        S_ERROR
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // fetch: ir_write and PC update are qualified by mem_ready outside
    typedef struct packed {
        logic       mem_req;
        logic       adr_src;
        logic       mem_write;
        logic       fetch;
        logic       pc_update;
        logic       branch;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } moore_t;

    function automatic moore_t moore_outputs(state_t s);
        moore_t m;
        m = '0;
        case (s)
            S_FETCH: begin
                m.mem_req    = 1'b1;
                m.fetch      = 1'b1;
                m.alu_src_a  = SRCA_PC;
                m.alu_src_b  = SRCB_FOUR;
                m.alu_op     = ALU_OP_ADD;
                m.result_src = RES_ALURESULT;
            end
            S_DECODE: begin
                m.alu_src_a = SRCA_OLDPC;
                m.alu_src_b = SRCB_IMM;
                m.alu_op    = ALU_OP_ADD;
            end
            S_MEMADR: begin
                m.alu_src_a = SRCA_RS1;
                m.alu_src_b = SRCB_IMM;
                m.alu_op    = ALU_OP_ADD;
            end
            S_MEMREAD: begin
                m.mem_req    = 1'b1;
                m.adr_src    = 1'b1;
                m.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                m.result_src = RES_DATA;
                m.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                m.mem_req    = 1'b1;
                m.adr_src    = 1'b1;
                m.mem_write  = 1'b1;
                m.result_src = RES_ALUOUT;
            end
            S_EXECUTER: begin
                m.alu_src_a = SRCA_RS1;
                m.alu_src_b = SRCB_RS2;
                m.alu_op    = ALU_OP_FUNCT;
            end
            S_EXECUTEI: begin
                m.alu_src_a = SRCA_RS1;
                m.alu_src_b = SRCB_IMM;
                m.alu_op    = ALU_OP_FUNCT;
            end
            S_ALUWB: begin
                m.result_src = RES_ALUOUT;
                m.reg_write  = 1'b1;
            end
            S_BEQ: begin
                m.alu_src_a  = SRCA_RS1;
                m.alu_src_b  = SRCB_RS2;
                m.alu_op     = ALU_OP_SUB;
                m.result_src = RES_ALUOUT;
                m.branch     = 1'b1;
            end
            S_JAL: begin
                m.alu_src_a  = SRCA_OLDPC;
                m.alu_src_b  = SRCB_FOUR;
                m.alu_op     = ALU_OP_ADD;
                m.result_src = RES_ALUOUT;
                m.pc_update  = 1'b1;
            end
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/instr_imm_decoder.sv
// rtl/instr_imm_decoder.sv - opcode to immediate-format select
// Ports: op (opcode field), imm_src (I/S/B/J immediate format select).
module instr_imm_decoder
    import ctrl_pkg::*;
#(
    parameter int OP_W = 7
) (
    input  logic [OP_W-1:0] op,
    output logic [1:0]      imm_src
);

    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle RV32I main control FSM
// Inputs: clk, reset (sync, active-high), op, zero, mem_ready.
// Outputs: mem_req, pc_write, adr_src, mem_write, ir_write, reg_write,
// result_src, alu_src_a, alu_src_b, alu_op, imm_src, illegal_instr.
module multicycle_control_fsm
    import ctrl_pkg::*;
#(
    parameter int OP_W             = 7,
    parameter bit ILLEGAL_TO_FETCH = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] op,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            mem_req,
    output logic            pc_write,
    output logic            adr_src,
    output logic            mem_write,
    output logic            ir_write,
    output logic            reg_write,
    output logic [1:0]      result_src,
    output logic [1:0]      alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      alu_op,
    output logic [1:0]      imm_src,
    output logic            illegal_instr
);

    state_t state;
    state_t state_nxt;
    moore_t moore_q;
    logic   illegal_nxt;
    logic   illegal_q;

    always_comb begin
        state_nxt   = state;
        illegal_nxt = 1'b0;
        case (state)
            S_FETCH:    if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_R:         state_nxt = S_EXECUTER;
                    OP_IALU:      state_nxt = S_EXECUTEI;
                    OP_BEQ:       state_nxt = S_BEQ;
                    OP_JAL:       state_nxt = S_JAL;
                    default: begin
                        illegal_nxt = 1'b1;
                        state_nxt   = ILLEGAL_TO_FETCH ? S_FETCH : S_ERROR;
                    end
                endcase
            end
            S_MEMADR:   state_nxt = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) state_nxt = S_MEMWB;
            S_MEMWB:    state_nxt = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_nxt = S_FETCH;
            S_EXECUTER: state_nxt = S_ALUWB;
            S_EXECUTEI: state_nxt = S_ALUWB;
            S_ALUWB:    state_nxt = S_FETCH;
            S_BEQ:      state_nxt = S_FETCH;
            S_JAL:      state_nxt = S_ALUWB;
            S_ERROR:    state_nxt = S_ERROR;
            default:    state_nxt = S_FETCH;
        endcase
    end

    // Moore outputs are registered alongside the state they belong to, and
    // the illegal-opcode pulse lands in the cycle after DECODE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_FETCH;
            moore_q   <= moore_outputs(S_FETCH);
            illegal_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            moore_q   <= moore_outputs(state_nxt);
            illegal_q <= illegal_nxt;
        end
    end

    // Strobes are masked by reset directly so an instruction interrupted by
    // reset never issues a partial register or memory write.
    assign mem_req       = moore_q.mem_req & ~reset;
    assign mem_write     = moore_q.mem_write & ~reset;
    assign reg_write     = moore_q.reg_write & ~reset;
    assign ir_write      = moore_q.fetch & mem_ready & ~reset;
    assign pc_write      = (moore_q.pc_update | (moore_q.fetch & mem_ready)
                           | (moore_q.branch & zero)) & ~reset;
    assign illegal_instr = illegal_q & ~reset;
    assign adr_src       = moore_q.adr_src;
    assign result_src    = moore_q.result_src;
    assign alu_src_a     = moore_q.alu_src_a;
    assign alu_src_b     = moore_q.alu_src_b;
    assign alu_op        = moore_q.alu_op;

    instr_imm_decoder #(
        .OP_W(OP_W)
    ) u_imm_dec (
        .op      (op),
        .imm_src (imm_src)
    );

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - self-checking bench for multicycle_control_fsm
module tb_multicycle_control_fsm;

    localparam logic [6:0] T_LW   = 7'b0000011;
    localparam logic [6:0] T_SW   = 7'b0100011;
    localparam logic [6:0] T_R    = 7'b0110011;
    localparam logic [6:0] T_I    = 7'b0010011;
    localparam logic [6:0] T_BEQ  = 7'b1100011;
    localparam logic [6:0] T_JAL  = 7'b1101111;
    localparam logic [6:0] T_BAD  = 7'b1111111;

    localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3,
                   P_MEMWB = 4, P_MEMWRITE = 5, P_EXECR = 6, P_EXECI = 7,
                   P_ALUWB = 8, P_BEQ = 9, P_JAL = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
    logic       illegal_instr;

    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .clk           (clk),
        .reset         (reset),
        .op            (op),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .pc_write      (pc_write),
        .adr_src       (adr_src),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .result_src    (result_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .imm_src       (imm_src),
        .illegal_instr (illegal_instr)
    );

    typedef struct packed {
        logic       mem_req;
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] imm_src;
        logic       illegal_instr;
    } exp_t;

    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic        rdy;
        logic        z;
        logic        strobes_only;
        logic        wait_cyc;
        exp_t        e;
        logic [63:0] tag;
    } vec_t;

    vec_t plan[$];
    int   checks = 0;
    int   errors = 0;
    logic pend_illegal = 1'b0;

    function automatic logic [1:0] imm_of(logic [6:0] o);
        case (o)
            T_SW:    return 2'b01;
            T_BEQ:   return 2'b10;
            T_JAL:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic exp_t ph(int k, logic rdy, logic z);
        exp_t e = '0;
        case (k)
            P_FETCH:    begin e.mem_req = 1; e.alu_src_b = 2'b10; e.result_src = 2'b10;
                              e.ir_write = rdy; e.pc_write = rdy; end
            P_DECODE:   begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b01; end
            P_MEMADR:   begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; end
            P_MEMREAD:  begin e.mem_req = 1; e.adr_src = 1; end
            P_MEMWB:    begin e.result_src = 2'b01; e.reg_write = 1; end
            P_MEMWRITE: begin e.mem_req = 1; e.adr_src = 1; e.mem_write = 1; end
            P_EXECR:    begin e.alu_src_a = 2'b10; e.alu_op = 2'b10; end
            P_EXECI:    begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; e.alu_op = 2'b10; end
            P_ALUWB:    begin e.reg_write = 1; end
            P_BEQ:      begin e.alu_src_a = 2'b10; e.alu_op = 2'b01; e.pc_write = z; end
            P_JAL:      begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.pc_write = 1; end
            default:    e = '0;
        endcase
        return e;
    endfunction

    function automatic exp_t strobes_off(exp_t e);
        exp_t r = e;
        r.mem_req = 0; r.pc_write = 0; r.mem_write = 0;
        r.ir_write = 0; r.reg_write = 0; r.illegal_instr = 0;
        return r;
    endfunction

    task automatic push(input logic rst, input logic [6:0] o, input logic rdy,
                        input logic z, input exp_t e, input logic [63:0] tag);
        vec_t v;
        v.rst = rst; v.op = o; v.rdy = rdy; v.z = z; v.strobes_only = 1'b0;
        v.wait_cyc = 1'b0;
        v.e = e;
        v.e.imm_src = imm_of(o);
        v.e.illegal_instr = rst ? 1'b0 : pend_illegal;
        if (!rst) pend_illegal = 1'b0;
        v.tag = tag;
        plan.push_back(v);
    endtask

    task automatic push_wait(input logic [6:0] o, input exp_t e, input logic [63:0] tag);
        push(0, o, 0, rb(), e, tag);
        plan[plan.size()-1].wait_cyc = 1'b1;
    endtask

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    task automatic add_instr(input logic [6:0] o, input int fwait, input int mwait,
                             input logic z);
        logic r;
        for (int i = 0; i < fwait; i++) push_wait(o, ph(P_FETCH, 0, 0), "fetchw");
        push(0, o, 1, rb(), ph(P_FETCH, 1, 0), "fetch");
        r = rb(); push(0, o, r, rb(), ph(P_DECODE, 0, 0), "decode");
        case (o)
            T_LW: begin
                r = rb(); push(0, o, r, rb(), ph(P_MEMADR, 0, 0), "memadr");
                for (int i = 0; i < mwait; i++) push_wait(o, ph(P_MEMREAD, 0, 0), "memrdw");
                push(0, o, 1, rb(), ph(P_MEMREAD, 0, 0), "memread");
                r = rb(); push(0, o, r, rb(), ph(P_MEMWB, 0, 0), "memwb");
            end
            T_SW: begin
                r = rb(); push(0, o, r, rb(), ph(P_MEMADR, 0, 0), "memadr");
                for (int i = 0; i < mwait; i++) push_wait(o, ph(P_MEMWRITE, 0, 0), "memwrw");
                push(0, o, 1, rb(), ph(P_MEMWRITE, 0, 0), "memwrite");
            end
            T_R: begin
                r = rb(); push(0, o, r, rb(), ph(P_EXECR, 0, 0), "execr");
                r = rb(); push(0, o, r, rb(), ph(P_ALUWB, 0, 0), "aluwb");
            end
            T_I: begin
                r = rb(); push(0, o, r, rb(), ph(P_EXECI, 0, 0), "execi");
                r = rb(); push(0, o, r, rb(), ph(P_ALUWB, 0, 0), "aluwb");
            end
            T_BEQ: begin
                r = rb(); push(0, o, r, z, ph(P_BEQ, 0, z), "beq");
            end
            T_JAL: begin
                r = rb(); push(0, o, r, rb(), ph(P_JAL, 0, 0), "jal");
                r = rb(); push(0, o, r, rb(), ph(P_ALUWB, 0, 0), "aluwb");
            end
            default: pend_illegal = 1'b1;
        endcase
    endtask

    function automatic logic [6:0] rand_op();
        logic [6:0] o;
        case ($urandom_range(0, 6))
            0: return T_LW;
            1: return T_SW;
            2: return T_R;
            3: return T_I;
            4: return T_BEQ;
            5: return T_JAL;
            default: begin
                o = 7'($urandom_range(0, 127));
                while (o == T_LW || o == T_SW || o == T_R || o == T_I ||
                       o == T_BEQ || o == T_JAL)
                    o = 7'($urandom_range(0, 127));
                return o;
            end
        endcase
    endfunction

    initial begin
        vec_t  v;
        exp_t  act, m, strobe_m;

        strobe_m = '0;
        strobe_m.mem_req = 1; strobe_m.pc_write = 1; strobe_m.mem_write = 1;
        strobe_m.ir_write = 1; strobe_m.reg_write = 1; strobe_m.illegal_instr = 1;

        push(1, T_LW, 1, 0, '0, "rst0");
        plan[0].strobes_only = 1'b1;
        push(1, T_LW, 1, 0, strobes_off(ph(P_FETCH, 0, 0)), "rst1");

        add_instr(T_LW,  0, 0, 0);
        add_instr(T_SW,  0, 3, 0);
        add_instr(T_BEQ, 0, 0, 1);
        add_instr(T_BEQ, 0, 0, 0);
        add_instr(T_R,   1, 0, 0);
        add_instr(T_JAL, 0, 0, 0);
        add_instr(T_I,   2, 0, 0);
        add_instr(T_BAD, 0, 0, 0);
        add_instr(T_LW,  1, 2, 0);

        push(0, T_SW, 1, 0, ph(P_FETCH, 1, 0), "fetch");
        push(0, T_SW, 0, 0, ph(P_DECODE, 0, 0), "decode");
        push(0, T_SW, 0, 0, ph(P_MEMADR, 0, 0), "memadr");
        push_wait(T_SW, ph(P_MEMWRITE, 0, 0), "memwrw");
        push(1, T_SW, 1, 0, strobes_off(ph(P_MEMWRITE, 0, 0)), "rstmw");
        add_instr(T_R, 0, 0, 0);

        push(0, T_LW, 1, 0, ph(P_FETCH, 1, 0), "fetch");
        push(0, T_LW, 1, 0, ph(P_DECODE, 0, 0), "decode");
        push(0, T_LW, 1, 0, ph(P_MEMADR, 0, 0), "memadr");
        push(1, T_LW, 1, 0, strobes_off(ph(P_MEMREAD, 0, 0)), "rstmr");
        add_instr(T_BAD, 0, 0, 0);
        add_instr(T_JAL, 0, 0, 0);

        for (int n = 0; n < 80; n++)
            add_instr(rand_op(), $urandom_range(0, 3), $urandom_range(0, 3), rb());

        for (int i = 0; i < plan.size(); i++) begin
            v = plan[i];
            @(posedge clk);
            #1;
            reset = v.rst; op = v.op; mem_ready = v.rdy; zero = v.z;
            @(negedge clk);
            act.mem_req = mem_req;       act.pc_write = pc_write;
            act.adr_src = adr_src;       act.mem_write = mem_write;
            act.ir_write = ir_write;     act.reg_write = reg_write;
            act.result_src = result_src; act.alu_src_a = alu_src_a;
            act.alu_src_b = alu_src_b;   act.alu_op = alu_op;
            act.imm_src = imm_src;       act.illegal_instr = illegal_instr;
            m = v.strobes_only ? strobe_m : '1;
            checks++;
            if (v.rst) begin
                if ((act & m) !== (v.e & m)) begin
                    errors++;
                    $display("FAIL reset %s cycle %0d: got %h required %h", v.tag, i, act & m, v.e & m);
                end
            end else if (v.wait_cyc) begin
                if (act !== v.e) begin
                    errors++;
                    $display("FAIL wait %s cycle %0d: got %h required %h", v.tag, i, act, v.e);
                end
            end else begin
                if (act !== v.e) begin
                    errors++;
                    $display("FAIL %s cycle %0d: got %h required %h", v.tag, i, act, v.e);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
